// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame streaming path: sequencer states and the
// default frame geometry used by the reader, writer and benches.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC_WAIT,
    ST_HSYNC_WAIT,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH          = 768;
  localparam int DEF_HEIGHT         = 512;
  localparam int DEF_START_UP_DELAY = 100;
  localparam int DEF_HSYNC_DELAY    = 160;

  // Bit width for a count range, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: VSYNC start-up window, per-line blanking, then HSYNC beats
// of two pixels each with an incrementally tracked pixel address.
//
// state         | meaning
// ST_IDLE       | waiting for start, position cleared
// ST_VSYNC_WAIT | start-up window, VSYNC high
// ST_HSYNC_WAIT | line blanking, ready ignored
// ST_DATA       | HSYNC high, beat moves on out_ready
// ST_DONE       | one-cycle ctrl_done pulse
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int START_UP_DELAY = DEF_START_UP_DELAY,
  parameter int HSYNC_DELAY    = DEF_HSYNC_DELAY,
  parameter int ADDR_W         = $clog2(WIDTH*HEIGHT)
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             start,
  input  logic                             out_ready,
  output logic                             VSYNC,
  output logic                             HSYNC,
  output logic [ADDR_W-1:0]                pix_addr,
  output logic [clog2_min1(HEIGHT)-1:0]    row,
  output logic [clog2_min1(WIDTH)-1:0]     col,
  output logic                             busy,
  output logic                             ctrl_done
);

  localparam int ROW_W = clog2_min1(HEIGHT);
  localparam int COL_W = clog2_min1(WIDTH);
  localparam int CNT_W = clog2_min1((START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY);

  state_t           state;
  logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_val;
  logic             line_end, last_row;

  assign line_end = (col == COL_W'(WIDTH - 2));
  assign last_row = (row == ROW_W'(HEIGHT - 1));

  // Counter is loaded on the same edge that enters a wait state, so a load
  // of N-1 yields exactly N cycles in that state.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(START_UP_DELAY - 1);
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_VSYNC_WAIT: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(HSYNC_DELAY - 1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HSYNC_WAIT: cnt_en = !cnt_tc;
      ST_DATA: begin
        if (out_ready && line_end && !last_row) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(HSYNC_DELAY - 1);
        end
      end
      default: ;
    endcase
  end

  delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (HCLK),
    .rst      (HRESET),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      VSYNC     <= 1'b0;
      HSYNC     <= 1'b0;
      busy      <= 1'b0;
      ctrl_done <= 1'b0;
      pix_addr  <= '0;
      row       <= '0;
      col       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          row       <= '0;
          col       <= '0;
          pix_addr  <= '0;
          HSYNC     <= 1'b0;
          ctrl_done <= 1'b0;
          if (start) begin
            state <= ST_VSYNC_WAIT;
            VSYNC <= 1'b1;
            busy  <= 1'b1;
          end else begin
            VSYNC <= 1'b0;
            busy  <= 1'b0;
          end
        end
        ST_VSYNC_WAIT: begin
          if (cnt_tc) begin
            state <= ST_HSYNC_WAIT;
            VSYNC <= 1'b0;
          end
        end
        ST_HSYNC_WAIT: begin
          if (cnt_tc) begin
            state <= ST_DATA;
            HSYNC <= 1'b1;
          end
        end
        ST_DATA: begin
          if (out_ready) begin
            if (line_end) begin
              col   <= '0;
              HSYNC <= 1'b0;
              if (last_row) begin
                // Row stays on the last line, so step back to its start.
                state     <= ST_DONE;
                ctrl_done <= 1'b1;
                pix_addr  <= pix_addr - ADDR_W'(WIDTH - 2);
              end else begin
                state    <= ST_HSYNC_WAIT;
                row      <= row + ROW_W'(1);
                pix_addr <= pix_addr + ADDR_W'(2);
              end
            end else begin
              col      <= col + COL_W'(2);
              pix_addr <= pix_addr + ADDR_W'(2);
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ctrl_done <= 1'b0;
          busy      <= 1'b0;
          row       <= '0;
          col       <= '0;
          pix_addr  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with an 8x4 frame, 3-cycle start-up and
// 2-cycle blanking; per-cycle traces are compared against hand-computed tables.
module tb_frame_seq_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int S  = 3;
  localparam int HD = 2;
  localparam int AW = $clog2(W*H);
  localparam int RW = 2;
  localparam int CW = 3;
  localparam int NMAX = 64;

  logic          HCLK = 1'b0;
  logic          HRESET, start, out_ready;
  logic          VSYNC, HSYNC, busy, ctrl_done;
  logic [AW-1:0] pix_addr;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  frame_seq_ctrl #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(S), .HSYNC_DELAY(HD), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .out_ready(out_ready),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .pix_addr(pix_addr), .row(row), .col(col),
    .busy(busy), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int   cyc;
    logic vs;
    logic hs;
    int   addr;
    int   rw;
    int   cl;
    logic bz;
    logic dn;
  } vec_t;

  vec_t tbl[15];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode;
  logic vs_t[NMAX], hs_t[NMAX], bz_t[NMAX], dn_t[NMAX];
  int   ad_t[NMAX], rw_t[NMAX], cl_t[NMAX];
  int   beats[$];
  int   dones[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic st_f(input int n);
    case (mode)
      3:       return (n == 0) || (n == 2) || (n == 20);
      5:       return 1'b1;
      default: return (n == 0);
    endcase
  endfunction

  function automatic logic rdy_f(input int n);
    case (mode)
      1:       return !(n >= 14 && n <= 16);
      2:       return !(n inside {4, 5, 10, 11, 16, 17, 22, 23});
      default: return 1'b1;
    endcase
  endfunction

  // Cycle n is the one after edge k+n-1; start for edge k is driven in cycle 0.
  task automatic run(input int m, input int ncyc);
    mode = m;
    beats.delete();
    dones.delete();
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge HCLK);
      vs_t[n] = VSYNC;  hs_t[n] = HSYNC;  bz_t[n] = busy;  dn_t[n] = ctrl_done;
      ad_t[n] = int'(pix_addr);  rw_t[n] = int'(row);  cl_t[n] = int'(col);
      if (ctrl_done) dones.push_back(n);
      start     = st_f(n);
      out_ready = rdy_f(n);
      if (HSYNC && out_ready) beats.push_back(int'(pix_addr));
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_table(input string tag, input int off);
    for (int i = 0; i < 15; i++) begin
      int c;
      c = tbl[i].cyc + off;
      chk($sformatf("%s c%0d vsync", tag, c), int'(vs_t[c]), int'(tbl[i].vs));
      chk($sformatf("%s c%0d hsync", tag, c), int'(hs_t[c]), int'(tbl[i].hs));
      chk($sformatf("%s c%0d addr",  tag, c), ad_t[c], tbl[i].addr);
      chk($sformatf("%s c%0d row",   tag, c), rw_t[c], tbl[i].rw);
      chk($sformatf("%s c%0d col",   tag, c), cl_t[c], tbl[i].cl);
      chk($sformatf("%s c%0d busy",  tag, c), int'(bz_t[c]), int'(tbl[i].bz));
      chk($sformatf("%s c%0d done",  tag, c), int'(dn_t[c]), int'(tbl[i].dn));
    end
  endtask

  task automatic check_beats(input string tag);
    chk({tag, " beat count"}, beats.size(), 16);
    for (int i = 0; i < beats.size() && i < 16; i++)
      chk($sformatf("%s beat%0d addr", tag, i), beats[i], 2*i);
  endtask

  task automatic check_dones(input string tag, input int exp_n, input int c0, input int c1);
    chk({tag, " done count"}, dones.size(), exp_n);
    if (dones.size() > 0) chk({tag, " done cycle0"}, dones[0], c0);
    if (exp_n > 1 && dones.size() > 1) chk({tag, " done cycle1"}, dones[1], c1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " vsync"}, int'(VSYNC), 0);
    chk({tag, " hsync"}, int'(HSYNC), 0);
    chk({tag, " busy"},  int'(busy), 0);
    chk({tag, " done"},  int'(ctrl_done), 0);
    chk({tag, " addr"},  int'(pix_addr), 0);
    chk({tag, " row"},   int'(row), 0);
    chk({tag, " col"},   int'(col), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cyc vs  hs  addr row col busy done
    tbl[0]  = '{ 1, 1, 0,  0, 0, 0, 1, 0};
    tbl[1]  = '{ 2, 1, 0,  0, 0, 0, 1, 0};
    tbl[2]  = '{ 3, 1, 0,  0, 0, 0, 1, 0};
    tbl[3]  = '{ 4, 0, 0,  0, 0, 0, 1, 0};
    tbl[4]  = '{ 5, 0, 0,  0, 0, 0, 1, 0};
    tbl[5]  = '{ 6, 0, 1,  0, 0, 0, 1, 0};
    tbl[6]  = '{ 9, 0, 1,  6, 0, 6, 1, 0};
    tbl[7]  = '{10, 0, 0,  8, 1, 0, 1, 0};
    tbl[8]  = '{12, 0, 1,  8, 1, 0, 1, 0};
    tbl[9]  = '{15, 0, 1, 14, 1, 6, 1, 0};
    tbl[10] = '{21, 0, 1, 22, 2, 6, 1, 0};
    tbl[11] = '{24, 0, 1, 24, 3, 0, 1, 0};
    tbl[12] = '{27, 0, 1, 30, 3, 6, 1, 0};
    tbl[13] = '{28, 0, 0, 24, 3, 0, 1, 1};
    tbl[14] = '{29, 0, 0,  0, 0, 0, 0, 0};

    HRESET = 1'b1;  start = 1'b0;  out_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    run(0, 30);
    check_table("nostall", 0);
    check_beats("nostall");
    check_dones("nostall", 1, 28, 0);

    run(1, 33);
    for (int c = 14; c <= 17; c++) begin
      chk($sformatf("stall c%0d addr", c), ad_t[c], 12);
      chk($sformatf("stall c%0d hsync", c), int'(hs_t[c]), 1);
      chk($sformatf("stall c%0d col", c), cl_t[c], 4);
    end
    chk("stall c18 addr", ad_t[18], 14);
    chk("stall c19 hsync", int'(hs_t[19]), 0);
    check_beats("stall");
    check_dones("stall", 1, 31, 0);

    run(2, 30);
    check_table("blankrdy", 0);
    check_beats("blankrdy");
    check_dones("blankrdy", 1, 28, 0);

    run(3, 40);
    check_table("busystart", 0);
    check_dones("busystart", 1, 28, 0);
    chk("busystart c30 busy", int'(bz_t[30]), 0);
    chk("busystart c40 vsync", int'(vs_t[40]), 0);

    // Abort at row 2, then a fresh frame must start clean.
    run(0, 18);
    chk("abort pre row", int'(row), 2);
    chk("abort pre busy", int'(busy), 1);
    HRESET = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    run(0, 30);
    check_table("afterabort", 0);
    check_beats("afterabort");
    check_dones("afterabort", 1, 28, 0);

    run(5, 60);
    check_table("b2b f1", 0);
    check_table("b2b f2", 29);
    check_dones("b2b", 2, 28, 57);
    chk("b2b c30 vsync", int'(vs_t[30]), 1);

    HRESET = 1'b1;
    #1;
    check_all_zero("final reset");
    @(negedge HCLK);
    HRESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
